// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared constants and helpers for the branch predict unit:
//                2-bit counter encodings, BTB field widths and saturating
//                counter arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // 2-bit saturating counter states; bit 1 is the taken prediction
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Index width of a BTB with the given number of entries
    function automatic int idx_width(input int entries);
        return $clog2(entries);
    endfunction

    // Tag width: PC bits left over after the byte offset and the index
    function automatic int tag_width(input int pc_w, input int entries);
        return pc_w - 2 - $clog2(entries);
    endfunction

    function automatic logic [1:0] sat_inc2(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec2(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btb_table.sv
`default_nettype none
// ============================================================================
//  Module      : btb_table
//  Description : Flop-based direct-mapped branch target buffer storage.
//                Two combinational read ports (fetch lookup, execute hit
//                check), one synchronous write port, one-cycle reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module btb_table
    import branch_pkg::*;
#(
    parameter  int PC_W    = 9,
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = idx_width(ENTRIES),
    localparam int TAG_W   = tag_width(PC_W, ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    // fetch read port
    input  logic [IDX_W-1:0] rd_f_idx,
    output logic             rd_f_valid,
    output logic [TAG_W-1:0] rd_f_tag,
    output logic [PC_W-1:0]  rd_f_target,
    output logic [1:0]       rd_f_ctr,
    // execute read port
    input  logic [IDX_W-1:0] rd_e_idx,
    output logic             rd_e_valid,
    output logic [TAG_W-1:0] rd_e_tag,
    output logic [PC_W-1:0]  rd_e_target,
    output logic [1:0]       rd_e_ctr,
    // write port; a write always leaves the entry valid
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [PC_W-1:0]  wr_target,
    input  logic [1:0]       wr_ctr
);

    logic             w_valid  [ENTRIES];
    logic [TAG_W-1:0] w_tag    [ENTRIES];
    logic [PC_W-1:0]  w_target [ENTRIES];
    logic [1:0]       w_ctr    [ENTRIES];

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic             r_valid;
        logic [TAG_W-1:0] r_tag;
        logic [PC_W-1:0]  r_target;
        logic [1:0]       r_ctr;

        // Per-entry flops: reset restores the empty/weakly-not-taken state, else accept writes to this index
        always_ff @(posedge clk) begin
            if (reset) begin
                r_valid  <= 1'b0;
                r_tag    <= '0;
                r_target <= '0;
                r_ctr    <= WNT;
            end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                r_valid  <= 1'b1;
                r_tag    <= wr_tag;
                r_target <= wr_target;
                r_ctr    <= wr_ctr;
            end
        end

        assign w_valid[gi]  = r_valid;
        assign w_tag[gi]    = r_tag;
        assign w_target[gi] = r_target;
        assign w_ctr[gi]    = r_ctr;
    end

    // Reads see the stored (pre-update) value; there is no write bypass
    assign rd_f_valid  = w_valid[rd_f_idx];
    assign rd_f_tag    = w_tag[rd_f_idx];
    assign rd_f_target = w_target[rd_f_idx];
    assign rd_f_ctr    = w_ctr[rd_f_idx];

    assign rd_e_valid  = w_valid[rd_e_idx];
    assign rd_e_tag    = w_tag[rd_e_idx];
    assign rd_e_target = w_target[rd_e_idx];
    assign rd_e_ctr    = w_ctr[rd_e_idx];

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_unit
//  Description : Execute-stage branch resolution with a fetch-stage BTB
//                predictor (2-bit counters), misprediction redirect, table
//                training and saturating statistics counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter  int PC_W    = 9,
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = idx_width(ENTRIES),
    localparam int TAG_W   = tag_width(PC_W, ENTRIES)
) (
    input  logic            clk,
    input  logic            reset,
    // fetch-side prediction
    input  logic [PC_W-1:0] F_PC,
    output logic            Pred_Taken,
    output logic [PC_W-1:0] Pred_Target,
    // execute-side resolution
    input  logic            E_Valid,
    input  logic [PC_W-1:0] E_PC,
    input  logic            E_Branch,
    input  logic            E_JmpSel,
    input  logic            E_JalrSel,
    input  logic [31:0]     E_Imm,
    input  logic [31:0]     E_AluResult,
    input  logic            E_PredTaken,
    input  logic [PC_W-1:0] E_PredTarget,
    input  logic            flag_halt,
    output logic            Redirect,
    output logic [31:0]     Redirect_PC,
    output logic [31:0]     PC_Four,
    // statistics
    output logic [15:0]     Branch_Cnt,
    output logic [15:0]     Mispred_Cnt
);

    // ---------------- table ----------------
    logic [IDX_W-1:0] w_f_idx, w_e_idx;
    logic [TAG_W-1:0] w_f_tag, w_e_tag;
    logic             w_f_valid, w_e_valid;
    logic [TAG_W-1:0] w_f_tag_rd, w_e_tag_rd;
    logic [PC_W-1:0]  w_f_target, w_e_target;
    logic [1:0]       w_f_ctr, w_e_ctr;

    logic             w_wr_en;
    logic [PC_W-1:0]  w_wr_target;
    logic [1:0]       w_wr_ctr;

    assign w_f_idx = F_PC[IDX_W+1:2];
    assign w_f_tag = F_PC[PC_W-1:IDX_W+2];
    assign w_e_idx = E_PC[IDX_W+1:2];
    assign w_e_tag = E_PC[PC_W-1:IDX_W+2];

    btb_table #(
        .PC_W    (PC_W),
        .ENTRIES (ENTRIES)
    ) u_btb (
        .clk         (clk),
        .reset       (reset),
        .rd_f_idx    (w_f_idx),
        .rd_f_valid  (w_f_valid),
        .rd_f_tag    (w_f_tag_rd),
        .rd_f_target (w_f_target),
        .rd_f_ctr    (w_f_ctr),
        .rd_e_idx    (w_e_idx),
        .rd_e_valid  (w_e_valid),
        .rd_e_tag    (w_e_tag_rd),
        .rd_e_target (w_e_target),
        .rd_e_ctr    (w_e_ctr),
        .wr_en       (w_wr_en),
        .wr_idx      (w_e_idx),
        .wr_tag      (w_e_tag),
        .wr_target   (w_wr_target),
        .wr_ctr      (w_wr_ctr)
    );

    // ---------------- fetch lookup ----------------
    logic w_f_hit;
    assign w_f_hit     = w_f_valid && (w_f_tag_rd == w_f_tag);
    assign Pred_Taken  = w_f_hit && w_f_ctr[1];
    assign Pred_Target = w_f_target;

    // ---------------- execute resolve ----------------
    logic        w_active;
    logic        w_is_cf;
    logic        w_act_taken;
    logic [31:0] w_pc_four;
    logic [31:0] w_act_tgt;
    logic        w_mispred;
    logic        w_e_hit;

    assign w_active    = E_Valid && !flag_halt;
    assign w_is_cf     = w_active && (E_Branch || E_JmpSel);
    assign w_act_taken = (E_Branch && E_AluResult[0]) || E_JmpSel;
    assign w_pc_four   = 32'(E_PC) + 32'd4;
    assign w_act_tgt   = E_JalrSel ? E_AluResult : (32'(E_PC) + E_Imm);

    // A non-control-flow instruction has act_taken=0, so gating with
    // w_active (not w_is_cf) also catches BTB aliasing: a stale taken
    // prediction on a plain instruction redirects back to E_PC+4.
    assign w_mispred = w_active &&
                       ((w_act_taken != E_PredTaken) ||
                        (w_act_taken && (w_act_tgt[PC_W-1:0] != E_PredTarget)));

    assign Redirect    = w_mispred;
    assign Redirect_PC = !w_mispred  ? 32'd0 :
                         w_act_taken ? w_act_tgt : w_pc_four;
    assign PC_Four     = flag_halt ? 32'd0 : w_pc_four;

    // ---------------- training ----------------
    assign w_e_hit = w_e_valid && (w_e_tag_rd == w_e_tag);

    // Train a hit entry's counter/target, or allocate on a taken miss
    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_target = w_e_target;
        w_wr_ctr    = w_e_ctr;
        if (w_is_cf) begin
            if (w_e_hit) begin
                w_wr_en  = 1'b1;
                w_wr_ctr = w_act_taken ? sat_inc2(w_e_ctr) : sat_dec2(w_e_ctr);
                if (w_act_taken) begin
                    w_wr_target = w_act_tgt[PC_W-1:0];
                end
            end else if (w_act_taken) begin
                w_wr_en     = 1'b1;
                w_wr_target = w_act_tgt[PC_W-1:0];
                w_wr_ctr    = E_JmpSel ? ST : WT;
            end
        end
    end

    // ---------------- statistics ----------------
    logic [15:0] r_branch_cnt;
    logic [15:0] r_mispred_cnt;

    // Saturating counts of resolved control flow and of issued redirects
    always_ff @(posedge clk) begin
        if (reset) begin
            r_branch_cnt  <= 16'd0;
            r_mispred_cnt <= 16'd0;
        end else begin
            if (w_is_cf) begin
                r_branch_cnt <= sat_inc16(r_branch_cnt);
            end
            if (w_mispred) begin
                r_mispred_cnt <= sat_inc16(r_mispred_cnt);
            end
        end
    end

    assign Branch_Cnt  = r_branch_cnt;
    assign Mispred_Cnt = r_mispred_cnt;

    // Byte-offset bits and the counter hysteresis bit play no role in the lookup
    logic w_unused;
    assign w_unused = ^{F_PC[1:0], w_f_ctr[0]};

endmodule
`default_nettype wire
